dir_rom_arbiter: RTL

DIR_ROM_ARBITER -- requirements
Module: dir_rom_arbiter

---
 rtl/dir_rom_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dir_rom_arbiter.sv
// dir_rom_arbiter
//   Round-robin arbiter that lets NREQ requesters share one combinational
//   orientation ROM through a two-stage pipeline (S1: address, S2: data).
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   req_valid   per-requester lookup request            [NREQ]
//   req_addr    per-requester address, i at [i*AW +: AW] [NREQ*AW]
//   req_ready   one-hot (or zero) grant                 [NREQ]
//   rom_addr    address to the shared ROM               [AW]
//   rom_data    ROM data, combinational from rom_addr   [DW]
//   rsp_valid   one-hot response valid, tagged by id    [NREQ]
//   rsp_data    looked-up orientation bin               [DW]
//   rsp_ready   shared response-sink accept
//   lookup_cnt  saturating count of response transfers  [16]

module dir_rom_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned AW   = 8,
   parameter int unsigned DW   = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   output logic [NREQ-1:0]    req_ready,
   output logic [AW-1:0]      rom_addr,
   input  logic [DW-1:0]      rom_data,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [DW-1:0]      rsp_data,
   input  logic               rsp_ready,
   output logic [15:0]        lookup_cnt
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Stage 1: accepted request waiting on the ROM
   logic          v1_q, v1_d;
   logic [IW-1:0] id1_q, id1_d;
   logic [AW-1:0] addr1_q, addr1_d;
   // Stage 2: ROM result waiting on the response sink
   logic          v2_q, v2_d;
   logic [IW-1:0] id2_q, id2_d;
   logic [DW-1:0] data2_q, data2_d;

   logic [IW-1:0] ptr_q, ptr_d;
   logic [15:0]   cnt_q, cnt_d;

   logic            adv1, adv2;
   logic            grant_any;
   logic [IW-1:0]   grant_idx;
   logic [NREQ-1:0] grant_oh;
   logic [AW-1:0]   grant_addr;
   logic            rsp_xfer;

   assign adv2     = !v2_q || rsp_ready;
   assign adv1     = !v1_q || adv2;
   assign rsp_xfer = v2_q && rsp_ready;

   // Round-robin search: first asserted req_valid at or above ptr, wrapping.
   always_comb begin
      grant_any  = 1'b0;
      grant_idx  = '0;
      grant_oh   = '0;
      grant_addr = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
         for (int i = 0; i < int'(NREQ); i++) begin
            if (!grant_any && (i == ((int'(ptr_q) + k) % int'(NREQ))) && req_valid[i]) begin
               grant_any = 1'b1;
               grant_idx = IW'(i);
            end
         end
      end
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant_any && (grant_idx == IW'(i))) begin
            grant_oh[i] = 1'b1;
            grant_addr  = req_addr[i*AW +: AW];
         end
      end
   end

   // Next-state logic for both stages, the pointer and the counter
   always_comb begin
      v1_d    = v1_q;
      id1_d   = id1_q;
      addr1_d = addr1_q;
      v2_d    = v2_q;
      id2_d   = id2_q;
      data2_d = data2_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;

      if (adv2) begin
         v2_d    = v1_q;
         id2_d   = id1_q;
         data2_d = rom_data;
      end

      if (adv1) begin
         v1_d = grant_any;
         if (grant_any) begin
            id1_d   = grant_idx;
            addr1_d = grant_addr;
            ptr_d   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
         end
      end

      if (rsp_xfer && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         id1_q   <= '0;
         addr1_q <= '0;
         v2_q    <= 1'b0;
         id2_q   <= '0;
         data2_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         id1_q   <= id1_d;
         addr1_q <= addr1_d;
         v2_q    <= v2_d;
         id2_q   <= id2_d;
         data2_q <= data2_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are forced to zero while rst_n is low, even before the first
   // reset edge has cleared the registers.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_data  = '0;
      rom_addr  = '0;
      if (rst_n) begin
         req_ready = adv1 ? grant_oh : '0;
         rom_addr  = addr1_q;
         rsp_data  = data2_q;
         if (v2_q) begin
            rsp_valid = NREQ'(1) << id2_q;
         end
      end
   end

   assign lookup_cnt = cnt_q;

endmodule
